// File: rtl/img_lut_loader.sv
// -----------------------------------------------------------------------------
// img_lut_loader
//
// Bulk-programs an image LUT through its AXI4-Lite CSR slave. LUT entries
// arrive on an AXI4-Stream, one entry per beat, and each beat becomes exactly
// one AXI4-Lite write to LUT_BASE_ADDR + 4*index. Only one write is ever in
// flight: the next beat is not accepted until the B response has returned.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   start_i               one-cycle pulse, starts a load (only honoured in IDLE)
//   busy_o                high from accepted start until the done pulse
//   done_o                one-cycle pulse at the end of a load
//   last_err_o            sticky: tlast was early or missing in the last load
//   resp_err_cnt_o        saturating count of non-OKAY write responses
//   lut_i_*               AXI4-Stream entry input (tdata, tvalid, tlast, tready)
//   csr_aw*/csr_w*/csr_b* AXI4-Lite write channels toward the LUT CSR slave
//
// State table
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start_i
//   GET    | tready high, waiting for the next stream beat
//   ADDR   | awvalid/wvalid presented, each drops after its own handshake
//   RESP   | bready high, waiting for the write response
//   FIN    | one-cycle done pulse, back to IDLE
// -----------------------------------------------------------------------------
module img_lut_loader #(
  parameter logic [31:0] LUT_BASE_ADDR = 32'h0000_0000,
  parameter int          PX_WIDTH      = 10,
  parameter int          TDATA_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,

  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   last_err_o,
  output logic [7:0]             resp_err_cnt_o,

  input  logic [TDATA_WIDTH-1:0] lut_i_tdata,
  input  logic                   lut_i_tvalid,
  input  logic                   lut_i_tlast,
  output logic                   lut_i_tready,

  output logic                   csr_awvalid,
  output logic [31:0]            csr_awaddr,
  output logic [2:0]             csr_awprot,
  input  logic                   csr_awready,

  output logic                   csr_wvalid,
  output logic [31:0]            csr_wdata,
  output logic [3:0]             csr_wstrb,
  input  logic                   csr_wready,

  input  logic                   csr_bvalid,
  input  logic [1:0]             csr_bresp,
  output logic                   csr_bready
);

  // The final index is all ones, so the index register can never wrap
  // inside a load: the end-of-load check fires first.
  localparam logic [PX_WIDTH-1:0] LAST_IDX = {PX_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GET  = 3'd1,
    S_ADDR = 3'd2,
    S_RESP = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [PX_WIDTH-1:0] index_q;
  logic                tlast_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic [31:0]         awaddr_q;
  logic [31:0]         wdata_q;
  logic                last_err_q;
  logic [7:0]          resp_err_cnt_q;

  logic start_ok;
  logic beat_fire;
  logic b_fire;
  logic aw_pending;
  logic w_pending;
  logic at_last;
  logic end_load;
  logic bad_last;

  logic [31:0] entry_offset;
  logic [31:0] entry_data;

  // Bits of tdata above the entry width carry no meaning for the LUT.
  if (TDATA_WIDTH > PX_WIDTH) begin : g_tdata_hi
    logic unused_tdata_hi;
    assign unused_tdata_hi = ^lut_i_tdata[TDATA_WIDTH-1:PX_WIDTH];
  end

  assign entry_offset = {{(30-PX_WIDTH){1'b0}}, index_q, 2'b00};
  assign entry_data   = {{(32-PX_WIDTH){1'b0}}, lut_i_tdata[PX_WIDTH-1:0]};

  assign start_ok  = (state_q == S_IDLE) && start_i;
  assign beat_fire = (state_q == S_GET)  && lut_i_tvalid;
  assign b_fire    = (state_q == S_RESP) && csr_bvalid;

  // A channel is still pending if its valid is up and this cycle is not
  // the handshake; ADDR ends once neither channel is pending.
  assign aw_pending = awvalid_q && !csr_awready;
  assign w_pending  = wvalid_q  && !csr_wready;

  // End of load: either the source flagged the last beat or the LUT is
  // full. Exactly one of the two is an error (early or missing tlast).
  assign at_last  = (index_q == LAST_IDX);
  assign end_load = tlast_q || at_last;
  assign bad_last = tlast_q ^ at_last;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    lut_i_tready = 1'b0;
    csr_bready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_GET;
        end
      end

      S_GET: begin
        busy_o       = 1'b1;
        lut_i_tready = 1'b1;
        if (lut_i_tvalid) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        busy_o = 1'b1;
        if (!aw_pending && !w_pending) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        busy_o     = 1'b1;
        csr_bready = 1'b1;
        if (csr_bvalid) begin
          state_d = end_load ? S_FIN : S_GET;
        end
      end

      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry capture and AXI write channels
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      index_q   <= '0;
      tlast_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      if (start_ok) begin
        index_q <= '0;
      end

      if (beat_fire) begin
        awaddr_q  <= LUT_BASE_ADDR + entry_offset;
        wdata_q   <= entry_data;
        tlast_q   <= lut_i_tlast;
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
      end

      // Address and data are held untouched until the next beat, so they
      // are stable for as long as either valid is high.
      if (state_q == S_ADDR) begin
        if (csr_awready) begin
          awvalid_q <= 1'b0;
        end
        if (csr_wready) begin
          wvalid_q <= 1'b0;
        end
      end

      if (b_fire && !end_load) begin
        index_q <= index_q + PX_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_err_q     <= 1'b0;
      resp_err_cnt_q <= '0;
    end else begin
      if (start_ok) begin
        last_err_q     <= 1'b0;
        resp_err_cnt_q <= '0;
      end else if (b_fire) begin
        if ((csr_bresp != 2'b00) && (resp_err_cnt_q != 8'hFF)) begin
          resp_err_cnt_q <= resp_err_cnt_q + 8'd1;
        end
        if (end_load && bad_last) begin
          last_err_q <= 1'b1;
        end
      end
    end
  end

  assign csr_awvalid    = awvalid_q;
  assign csr_awaddr     = awaddr_q;
  assign csr_awprot     = 3'b000;
  assign csr_wvalid     = wvalid_q;
  assign csr_wdata      = wdata_q;
  assign csr_wstrb      = 4'hF;
  assign last_err_o     = last_err_q;
  assign resp_err_cnt_o = resp_err_cnt_q;

endmodule

// File: tb/tb_img_lut_loader.sv
// -----------------------------------------------------------------------------
// tb_img_lut_loader
//
// Directed bench for img_lut_loader. The bench plays both the stream source
// and the AXI4-Lite slave, stepping everything on the falling clock edge so
// outputs are sampled and inputs driven away from the active edge.
// -----------------------------------------------------------------------------
module tb_img_lut_loader;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        last_err_o;
  logic [7:0]  resp_err_cnt_o;
  logic [15:0] lut_i_tdata;
  logic        lut_i_tvalid;
  logic        lut_i_tlast;
  logic        lut_i_tready;
  logic        csr_awvalid;
  logic [31:0] csr_awaddr;
  logic [2:0]  csr_awprot;
  logic        csr_awready;
  logic        csr_wvalid;
  logic [31:0] csr_wdata;
  logic [3:0]  csr_wstrb;
  logic        csr_wready;
  logic        csr_bvalid;
  logic [1:0]  csr_bresp;
  logic        csr_bready;

  int tests;
  int fails;

  img_lut_loader #(
    .LUT_BASE_ADDR (32'h0000_0000),
    .PX_WIDTH      (10),
    .TDATA_WIDTH   (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .last_err_o     (last_err_o),
    .resp_err_cnt_o (resp_err_cnt_o),
    .lut_i_tdata    (lut_i_tdata),
    .lut_i_tvalid   (lut_i_tvalid),
    .lut_i_tlast    (lut_i_tlast),
    .lut_i_tready   (lut_i_tready),
    .csr_awvalid    (csr_awvalid),
    .csr_awaddr     (csr_awaddr),
    .csr_awprot     (csr_awprot),
    .csr_awready    (csr_awready),
    .csr_wvalid     (csr_wvalid),
    .csr_wdata      (csr_wdata),
    .csr_wstrb      (csr_wstrb),
    .csr_wready     (csr_wready),
    .csr_bvalid     (csr_bvalid),
    .csr_bresp      (csr_bresp),
    .csr_bready     (csr_bready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All outputs in their reset/idle values.
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},    busy_o,         0);
    chk({tag, "_done"},    done_o,         0);
    chk({tag, "_tready"},  lut_i_tready,   0);
    chk({tag, "_awvalid"}, csr_awvalid,    0);
    chk({tag, "_awaddr"},  csr_awaddr,     0);
    chk({tag, "_wvalid"},  csr_wvalid,     0);
    chk({tag, "_wdata"},   csr_wdata,      0);
    chk({tag, "_bready"},  csr_bready,     0);
    chk({tag, "_lasterr"}, last_err_o,     0);
    chk({tag, "_errcnt"},  resp_err_cnt_o, 0);
    chk({tag, "_awprot"},  csr_awprot,     0);
    chk({tag, "_wstrb"},   csr_wstrb,      4'hF);
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge in GET.
  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("start_busy",    busy_o,         1);
    chk("start_done",    done_o,         0);
    chk("start_lasterr", last_err_o,     0);
    chk("start_errcnt",  resp_err_cnt_o, 0);
    chk("start_tready",  lut_i_tready,   1);
  endtask

  // One stream beat through to its B response. aw_d/w_d are the number of
  // ADDR cycles the slave holds the respective ready low.
  task automatic do_entry(input int idx, input logic [15:0] data, input logic last,
                          input int aw_d, input int w_d, input logic [1:0] br,
                          input logic exp_fin);
    int          n;
    int          k;
    logic        aw_done;
    logic        w_done;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;

    exp_addr = 32'(idx * 4);
    exp_data = {22'b0, data[9:0]};

    lut_i_tdata  = data;
    lut_i_tlast  = last;
    lut_i_tvalid = 1'b1;
    n = 0;
    while (lut_i_tready !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("beat_tready", lut_i_tready, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    // Garbage after the handshake must not reach the captured entry.
    lut_i_tvalid = 1'b0;
    lut_i_tlast  = 1'b0;
    lut_i_tdata  = 16'hFFFF;

    aw_done = 1'b0;
    w_done  = 1'b0;
    k = 0;
    while (!(aw_done && w_done) && k < 20) begin
      chk("awvalid", csr_awvalid, !aw_done);
      chk("wvalid",  csr_wvalid,  !w_done);
      if (csr_awvalid) chk("awaddr", csr_awaddr, exp_addr);
      if (csr_wvalid)  chk("wdata",  csr_wdata,  exp_data);
      chk("bready_in_addr", csr_bready, 0);
      chk("tready_in_addr", lut_i_tready, 0);
      csr_awready = !aw_done && (k >= aw_d);
      csr_wready  = !w_done  && (k >= w_d);
      @(posedge clk_i);
      if (csr_awready) aw_done = 1'b1;
      if (csr_wready)  w_done  = 1'b1;
      @(negedge clk_i);
      csr_awready = 1'b0;
      csr_wready  = 1'b0;
      k++;
    end
    chk("addr_phase_done", {31'b0, aw_done && w_done}, 1);
    chk("resp_awvalid", csr_awvalid, 0);
    chk("resp_wvalid",  csr_wvalid,  0);
    chk("resp_bready",  csr_bready,  1);

    csr_bvalid = 1'b1;
    csr_bresp  = br;
    @(posedge clk_i);
    @(negedge clk_i);
    csr_bvalid = 1'b0;
    csr_bresp  = 2'b00;
    chk("after_b_done",   done_o,       exp_fin);
    chk("after_b_busy",   busy_o,       !exp_fin);
    chk("after_b_tready", lut_i_tready, !exp_fin);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst_n_i      = 1'b0;
    start_i      = 1'b0;
    lut_i_tdata  = 16'h0;
    lut_i_tvalid = 1'b0;
    lut_i_tlast  = 1'b0;
    csr_awready  = 1'b0;
    csr_wready   = 1'b0;
    csr_bvalid   = 1'b0;
    csr_bresp    = 2'b00;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk_idle("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk_idle("post_reset");

    // Load 1: zero-wait slave, full 1024 entries, upper tdata bits set
    do_start();
    for (int i = 0; i < 1024; i++) begin
      do_entry(i, {6'h2B, i[9:0]}, (i == 1023), 0, 0, 2'b00, (i == 1023));
    end
    chk("l1_lasterr", last_err_o,     0);
    chk("l1_errcnt",  resp_err_cnt_o, 0);
    @(negedge clk_i);
    chk("l1_done_one_cycle", done_o, 0);
    chk("l1_idle_busy",      busy_o, 0);

    // Load 2: staggered aw/w ready, SLVERR on entries 5 and 6, start while busy
    do_start();
    for (int i = 0; i < 1024; i++) begin
      int aw_d;
      int w_d;
      case (i % 3)
        0:       begin aw_d = 3; w_d = 0; end
        1:       begin aw_d = 0; w_d = 3; end
        default: begin aw_d = 2; w_d = 2; end
      endcase
      if (i == 7) begin
        chk("l2_errcnt_mid", resp_err_cnt_o, 2);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("l2_busy_start_ignored",   busy_o,         1);
        chk("l2_errcnt_start_ignored", resp_err_cnt_o, 2);
      end
      do_entry(i, 16'(1023 - i), (i == 1023), aw_d, w_d,
               ((i == 5) || (i == 6)) ? 2'b10 : 2'b00, (i == 1023));
    end
    chk("l2_errcnt",  resp_err_cnt_o, 2);
    chk("l2_lasterr", last_err_o,     0);
    @(negedge clk_i);

    // Load 3: early tlast on beat 99
    do_start();
    for (int i = 0; i < 100; i++) begin
      do_entry(i, 16'(i * 7), (i == 99), 0, 0, 2'b00, (i == 99));
    end
    chk("l3_lasterr", last_err_o,     1);
    chk("l3_errcnt",  resp_err_cnt_o, 0);
    @(negedge clk_i);
    chk("l3_done_one_cycle", done_o,     0);
    chk("l3_lasterr_sticky", last_err_o, 1);

    // Load 4: no tlast on beat 1023, every response DECERR (counter saturates)
    do_start();
    for (int i = 0; i < 1024; i++) begin
      do_entry(i, 16'(i ^ 16'h0155), 1'b0, 0, 0, 2'b11, (i == 1023));
    end
    chk("l4_lasterr", last_err_o,     1);
    chk("l4_errcnt",  resp_err_cnt_o, 8'hFF);
    @(negedge clk_i);
    lut_i_tdata  = 16'h0123;
    lut_i_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("l4_beat1024_not_taken", lut_i_tready, 0);
      chk("l4_no_awvalid",         csr_awvalid,  0);
      @(negedge clk_i);
    end
    lut_i_tvalid = 1'b0;

    // Load 5: reset while entry 500 has awvalid high, then a clean load
    do_start();
    for (int i = 0; i < 500; i++) begin
      do_entry(i, 16'(i), 1'b0, 0, 0, 2'b00, 1'b0);
    end
    lut_i_tdata  = 16'(500);
    lut_i_tvalid = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    lut_i_tvalid = 1'b0;
    chk("l5_awvalid_before_rst", csr_awvalid, 1);
    chk("l5_awaddr_before_rst",  csr_awaddr,  32'd2000);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk_idle("after_rst");

    do_start();
    for (int i = 0; i < 1024; i++) begin
      do_entry(i, 16'(i), (i == 1023), 0, 0, 2'b00, (i == 1023));
    end
    chk("l6_lasterr", last_err_o,     0);
    chk("l6_errcnt",  resp_err_cnt_o, 0);
    @(negedge clk_i);
    chk("l6_done_one_cycle", done_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
